// File: rtl/counter_seq_checker.sv
// counter_seq_checker: consumer-side checker for a free-running binary counter.
// Samples Q on enabled edges and locks onto the expected modulo-2^WIDTH up or
// down sequence. Once locked, it flags every out-of-sequence sample and
// counts both errors and wrap-arounds. All outputs are registered.
module counter_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int DIR      = 0,  // 0 = count up by 1, 1 = count down by 1
  parameter int LOCK_LEN = 2,  // consecutive good transitions to lock (1..15)
  parameter int CNTW     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] Q,
  output logic             LOCKED,
  output logic             ERR,
  output logic             WRAP,
  output logic [CNTW-1:0]  ERR_CNT,
  output logic [CNTW-1:0]  WRAP_CNT,
  output logic [WIDTH-1:0] LAST_Q
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_LEN_W = 4'(LOCK_LEN);
  localparam logic [WIDTH-1:0] Q_MAX      = {WIDTH{1'b1}};
  localparam logic [CNTW-1:0]  CNT_MAX    = {CNTW{1'b1}};

  state_t           r_state;
  logic             r_valid;
  logic [3:0]       r_run;
  logic [WIDTH-1:0] r_last_q;
  logic             r_err;
  logic             r_wrap;
  logic [CNTW-1:0]  r_err_cnt;
  logic [CNTW-1:0]  r_wrap_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic             w_wrap_tr;
  logic [3:0]       w_run_inc;
  logic             w_sample;
  logic             w_err_nxt;
  logic             w_wrap_nxt;

  // Expected successor of the last sample; the wrap is the one transition
  // where the natural +/-1 carries out of the word.
  assign w_exp     = (DIR == 0) ? r_last_q + WIDTH'(1) : r_last_q - WIDTH'(1);
  assign w_match   = (Q == w_exp);
  assign w_wrap_tr = (DIR == 0) ? ((r_last_q == Q_MAX) && (Q == '0))
                                : ((r_last_q == '0) && (Q == Q_MAX));
  assign w_run_inc = r_run + 4'd1;
  // The first enabled sample after reset only loads LAST_Q; there is no
  // predecessor to compare against.
  assign w_sample  = EN && r_valid;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (RST) r_state <= ST_SEARCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: lock after LOCK_LEN good transitions, drop on any miss.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (w_sample) begin
      unique case (r_state)
        ST_SEARCH: if (w_match && (w_run_inc == LOCK_LEN_W)) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (!w_match)                              w_state_nxt = ST_SEARCH;
        default:   w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  // Output decode: ERR and WRAP are only possible while locked and are
  // mutually exclusive because one needs a match and the other a miss.
  always_comb begin
    w_err_nxt  = w_sample && (r_state == ST_LOCKED) && !w_match;
    w_wrap_nxt = w_sample && (r_state == ST_LOCKED) && w_match && w_wrap_tr;
  end

  // Datapath: sample register, run counter, pulse flops, saturating counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid    <= 1'b0;
      r_run      <= '0;
      r_last_q   <= '0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      // Pulses default low so they last exactly one cycle per cause.
      r_err  <= w_err_nxt;
      r_wrap <= w_wrap_nxt;
      if (EN) begin
        // An erroneous sample still becomes LAST_Q, so re-acquisition counts
        // from it.
        r_last_q <= Q;
        if (!r_valid) begin
          r_valid <= 1'b1;
          r_run   <= '0;
        end else if (r_state == ST_SEARCH) begin
          r_run <= w_match ? w_run_inc : '0;
        end else if (!w_match) begin
          r_run <= '0;
        end
      end
      if (w_err_nxt && (r_err_cnt != CNT_MAX))   r_err_cnt  <= r_err_cnt + CNTW'(1);
      if (w_wrap_nxt && (r_wrap_cnt != CNT_MAX)) r_wrap_cnt <= r_wrap_cnt + CNTW'(1);
    end
  end

  assign LOCKED   = (r_state == ST_LOCKED);
  assign ERR      = r_err;
  assign WRAP     = r_wrap;
  assign ERR_CNT  = r_err_cnt;
  assign WRAP_CNT = r_wrap_cnt;
  assign LAST_Q   = r_last_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker. Three instances share one stimulus
// stream: an up checker, a down checker and an up checker with 2-bit counters.
module tb_counter_seq_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic [2:0] Q   = '0;

  logic       up_locked, up_err, up_wrap;
  logic [7:0] up_err_cnt, up_wrap_cnt;
  logic [2:0] up_last_q;
  logic       dn_locked, dn_err, dn_wrap;
  logic [7:0] dn_err_cnt, dn_wrap_cnt;
  logic [2:0] dn_last_q;
  logic       sat_locked, sat_err, sat_wrap;
  logic [1:0] sat_err_cnt, sat_wrap_cnt;
  logic [2:0] sat_last_q;

  int n_vec = 0;
  int n_mis = 0;

  counter_seq_checker #(.WIDTH(3), .DIR(0), .LOCK_LEN(2), .CNTW(8)) u_up (
    .CLK(CLK), .RST(RST), .EN(EN), .Q(Q),
    .LOCKED(up_locked), .ERR(up_err), .WRAP(up_wrap),
    .ERR_CNT(up_err_cnt), .WRAP_CNT(up_wrap_cnt), .LAST_Q(up_last_q));

  counter_seq_checker #(.WIDTH(3), .DIR(1), .LOCK_LEN(2), .CNTW(8)) u_dn (
    .CLK(CLK), .RST(RST), .EN(EN), .Q(Q),
    .LOCKED(dn_locked), .ERR(dn_err), .WRAP(dn_wrap),
    .ERR_CNT(dn_err_cnt), .WRAP_CNT(dn_wrap_cnt), .LAST_Q(dn_last_q));

  counter_seq_checker #(.WIDTH(3), .DIR(0), .LOCK_LEN(2), .CNTW(2)) u_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .Q(Q),
    .LOCKED(sat_locked), .ERR(sat_err), .WRAP(sat_wrap),
    .ERR_CNT(sat_err_cnt), .WRAP_CNT(sat_wrap_cnt), .LAST_Q(sat_last_q));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge; return 1 ns after the rising edge.
  task automatic tick(input int q, input bit en);
    @(negedge CLK);
    Q  = 3'(q);
    EN = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    EN  = 1'b0;
    Q   = '0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int t2_q[5]    = '{3, 4, 6, 7, 0};
  int t2_err[5]  = '{0, 0, 1, 0, 0};
  int t2_lock[5] = '{1, 1, 0, 0, 1};
  int t3_q[5]    = '{2, 1, 0, 7, 6};
  int t3_lock[5] = '{0, 0, 1, 1, 1};
  int t3_wrap[5] = '{0, 0, 0, 1, 0};
  int t4_q[3]    = '{7, 1, 5};
  int t5_q[9]    = '{0, 1, 2, 5, 6, 7, 2, 3, 4};

  initial begin
    // Reset state.
    #2;
    check("rst_locked", up_locked, 0);
    check("rst_last_q", up_last_q, 0);
    do_reset();

    // 1: up count 0..7,0,1; lock on the 3rd edge, one wrap on 7->0.
    for (int i = 0; i < 10; i++) begin
      tick(i % 8, 1'b1);
      check($sformatf("t1_locked[%0d]", i), up_locked, (i >= 2) ? 1 : 0);
      check($sformatf("t1_wrap[%0d]", i), up_wrap, (i == 8) ? 1 : 0);
      check($sformatf("t1_err[%0d]", i), up_err, 0);
    end
    check("t1_wrap_cnt", up_wrap_cnt, 1);
    check("t1_err_cnt", up_err_cnt, 0);
    check("t1_last_q", up_last_q, 1);

    // 2: from LAST_Q=2, sequence 3,4,6,7,0: error on 6, relock on 0.
    tick(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(t2_q[i], 1'b1);
      check($sformatf("t2_err[%0d]", i), up_err, t2_err[i]);
      check($sformatf("t2_locked[%0d]", i), up_locked, t2_lock[i]);
      check($sformatf("t2_wrap[%0d]", i), up_wrap, 0);
    end
    check("t2_err_cnt", up_err_cnt, 1);
    check("t2_wrap_cnt", up_wrap_cnt, 1);

    // 3: down count 2,1,0,7,6; up instance must never lock.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(t3_q[i], 1'b1);
      check($sformatf("t3_dn_locked[%0d]", i), dn_locked, t3_lock[i]);
      check($sformatf("t3_dn_wrap[%0d]", i), dn_wrap, t3_wrap[i]);
      check($sformatf("t3_up_locked[%0d]", i), up_locked, 0);
    end
    check("t3_dn_wrap_cnt", dn_wrap_cnt, 1);
    check("t3_dn_err_cnt", dn_err_cnt, 0);
    check("t3_up_err_cnt", up_err_cnt, 0);

    // 4: lock at 4, then three disabled edges of garbage, then 5.
    do_reset();
    tick(2, 1'b1);
    tick(3, 1'b1);
    tick(4, 1'b1);
    check("t4_locked", up_locked, 1);
    for (int i = 0; i < 3; i++) begin
      tick(t4_q[i], 1'b0);
      check($sformatf("t4_gap_last_q[%0d]", i), up_last_q, 4);
      check($sformatf("t4_gap_locked[%0d]", i), up_locked, 1);
      check($sformatf("t4_gap_err[%0d]", i), up_err, 0);
    end
    tick(5, 1'b1);
    check("t4_err", up_err, 0);
    check("t4_locked_after", up_locked, 1);
    check("t4_last_q", up_last_q, 5);

    // 5: build ERR_CNT=3 while ending locked, then async reset mid-cycle.
    for (int i = 0; i < 9; i++) tick(t5_q[i], 1'b1);
    check("t5_err_cnt", up_err_cnt, 3);
    check("t5_locked", up_locked, 1);
    #2;
    RST = 1'b1;
    #1;
    check("t5_rst_locked", up_locked, 0);
    check("t5_rst_err_cnt", up_err_cnt, 0);
    check("t5_rst_wrap_cnt", up_wrap_cnt, 0);
    check("t5_rst_last_q", up_last_q, 0);
    check("t5_rst_err", up_err, 0);
    check("t5_rst_wrap", up_wrap, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick(0, 1'b1);
    check("t5_post0_locked", up_locked, 0);
    tick(1, 1'b1);
    check("t5_post1_locked", up_locked, 0);
    tick(2, 1'b1);
    check("t5_post2_locked", up_locked, 1);

    // 6: five errors with relock between each; 2-bit counter stops at 3.
    begin
      int last_v;
      int bad;
      last_v = 2;
      for (int i = 0; i < 5; i++) begin
        bad = (last_v + 3) % 8;
        tick(bad, 1'b1);
        check($sformatf("t6_sat_err[%0d]", i), sat_err, 1);
        check($sformatf("t6_sat_err_cnt[%0d]", i), sat_err_cnt, (i + 1 > 3) ? 3 : i + 1);
        check($sformatf("t6_up_err_cnt[%0d]", i), up_err_cnt, i + 1);
        tick((bad + 1) % 8, 1'b1);
        check($sformatf("t6_sat_err_clr[%0d]", i), sat_err, 0);
        tick((bad + 2) % 8, 1'b1);
        check($sformatf("t6_sat_relock[%0d]", i), sat_locked, 1);
        last_v = (bad + 2) % 8;
      end
    end
    check("t6_sat_err_cnt_final", sat_err_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
